seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: 8-bit by 4-bit unsigned restoring divider, one quotient bit
// per clock, MSB first.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   dividend     8-bit unsigned numerator, captured on the accepting edge
//   divisor      4-bit unsigned denominator, captured on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse, results valid
//   quotient     8-bit quotient (8'hFF on divide by zero)
//   remainder    4-bit remainder (dividend[3:0] on divide by zero)
//   div_by_zero  set with done when the captured divisor was zero
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    localparam int unsigned DVD_W = 8;
    localparam int unsigned DVS_W = 4;
    localparam int unsigned REM_W = 5;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REM_W-1:0]   rem_q;
    logic [DVD_W-1:0]   dvd_q;
    logic [DVS_W-1:0]   dvs_q;

    logic [REM_W:0]     trial;
    logic               ge;
    logic [REM_W-1:0]   rem_next;

    // Trial subtraction of the shifted partial remainder; the top bit of
    // trial is the borrow, since the stored remainder never exceeds 4 bits.
    always_comb begin
        trial    = {rem_q, dvd_q[DVD_W-1]} - {2'b00, dvs_q};
        ge       = ~trial[REM_W];
        rem_next = ge ? trial[REM_W-1:0] : {rem_q[REM_W-2:0], dvd_q[DVD_W-1]};
    end

    // Control FSM and datapath. dvd_q shifts left each step and fills with
    // quotient bits, so after eight steps it holds the quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvs_q <= divisor;
                        cnt   <= '0;
                        rem_q <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd_q <= dividend;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[DVD_W-2:0], ge};
                    cnt   <= cnt + CNT_W'(1);
                    // Last step writes the results directly from the step logic.
                    if (cnt == CNT_W'(DVD_W - 1)) begin
                        quotient    <= {dvd_q[DVD_W-2:0], ge};
                        remainder   <= rem_next[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios, a randomized run
// and an exhaustive operand sweep, all checked against plain arithmetic.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer division, with the defined divide-by-zero result.
    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return 8'hFF;
        return 8'(int'(a) / int'(b));
    endfunction

    function automatic logic [3:0] ref_r(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return a[3:0];
        return 4'(int'(a) % int'(b));
    endfunction

    // Issue one operation at the current negedge and wait (bounded) for done.
    // Operands are scrambled right after acceptance. Returns at the negedge
    // following the done cycle, with done_after sampled there.
    task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic dz, output int lat, output int nbusy,
                          output logic done_after);
        q = 'x; r = 'x; dz = 1'bx; lat = -1; nbusy = 0;
        start = 1'b1; dividend = a; divisor = b;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            if (busy) nbusy++;
            if (done) begin
                lat = i; q = quotient; r = remainder; dz = div_by_zero;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    // Full check of one operation against the reference.
    task automatic check_op(input string tag, input logic [7:0] a, input logic [3:0] b);
        logic [7:0] q; logic [3:0] r; logic dz, da; int lat, nb;
        int exp_lat, exp_busy;
        exp_lat  = (b == 4'd0) ? 1 : 9;
        exp_busy = (b == 4'd0) ? 0 : 8;
        do_div(a, b, q, r, dz, lat, nb, da);
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency a=%0d b=%0d got=%0d exp=%0d", tag, a, b, lat, exp_lat);
        end
        checks++;
        if (q !== ref_q(a, b)) begin
            errors++; $display("FAIL %s quotient a=%0d b=%0d got=%0d exp=%0d", tag, a, b, q, ref_q(a, b));
        end
        checks++;
        if (r !== ref_r(a, b)) begin
            errors++; $display("FAIL %s remainder a=%0d b=%0d got=%0d exp=%0d", tag, a, b, r, ref_r(a, b));
        end
        checks++;
        if (dz !== (b == 4'd0)) begin
            errors++; $display("FAIL %s div_by_zero a=%0d b=%0d got=%0b exp=%0b", tag, a, b, dz, b == 4'd0);
        end
        checks++;
        if (nb !== exp_busy) begin
            errors++; $display("FAIL %s busy_cycles a=%0d b=%0d got=%0d exp=%0d", tag, a, b, nb, exp_busy);
        end
        checks++;
        if (da !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse a=%0d b=%0d got=%0b exp=0", tag, a, b, da);
        end
        // Results are held in idle after completion.
        checks++;
        if (quotient !== q || remainder !== r) begin
            errors++; $display("FAIL %s hold got=%0d/%0d exp=%0d/%0d", tag, quotient, remainder, q, r);
        end
        if (b != 4'd0) begin
            checks++;
            if ((int'(q) * int'(b) + int'(r)) != int'(a) || r >= b) begin
                errors++; $display("FAIL %s identity a=%0d b=%0d q=%0d r=%0d", tag, a, b, q, r);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++; $display("FAIL reset outputs got=%h exp=0", {busy, done, quotient, remainder, div_by_zero});
        end
    endtask

    // First start is driven in the same cycle rst drops; latency 9 proves
    // it was accepted on the first edge with rst low.
    task automatic test_basic();
        rst = 1'b0;
        check_op("basic_200_7", 8'd200, 4'd7);
    endtask

    task automatic test_corners();
        logic [7:0] as [6] = '{8'd255, 8'd15, 8'd3, 8'd0, 8'd255, 8'd128};
        logic [3:0] bs [6] = '{4'd1, 4'd15, 4'd9, 4'd5, 4'd15, 4'd2};
        for (int i = 0; i < 6; i++) check_op("corner", as[i], bs[i]);
    endtask

    task automatic test_div_zero();
        check_op("dbz_5_0", 8'd5, 4'd0);
        check_op("after_dbz_100_10", 8'd100, 4'd10);
        check_op("dbz_255_0", 8'd255, 4'd0);
    endtask

    task automatic test_abort();
        int ndone = 0;
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++; $display("FAIL abort_clear got=%h exp=0", {busy, done, quotient, remainder, div_by_zero});
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone);
        end
        check_op("after_abort_200_7", 8'd200, 4'd7);
    endtask

    // Start re-pulsed (with new operands) during CALC and during DONE.
    task automatic test_ignore_start();
        int ndone = 0, done_cyc = -1;
        logic [7:0] q = '0; logic [3:0] r = '0;
        logic pulse_next = 1'b0;
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 3) begin start = 1'b1; dividend = 8'd77; divisor = 4'd3; end
            if (cyc == 6) begin start = 1'b1; divisor = 4'd0; end
            if (pulse_next) pulse_next = 1'b0;
            if (done) begin
                ndone++; done_cyc = cyc; q = quotient; r = remainder;
                start = 1'b1; pulse_next = 1'b1;
            end
        end
        checks++;
        if (ndone != 1 || done_cyc != 9) begin
            errors++; $display("FAIL ignore_done count=%0d cyc=%0d exp=1/9", ndone, done_cyc);
        end
        checks++;
        if (q !== 8'd28 || r !== 4'd4) begin
            errors++; $display("FAIL ignore_result got=%0d/%0d exp=28/4", q, r);
        end
    endtask

    // start held high: a new operation begins on each return to idle.
    task automatic test_back_to_back();
        int ndone = 0, c1 = -1, c2 = -1;
        logic [7:0] q1 = '0, q2 = '0; logic [3:0] r1 = '0, r2 = '0;
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin dividend = 8'd100; divisor = 4'd10; end
            if (done) begin
                ndone++;
                if (ndone == 1) begin c1 = cyc; q1 = quotient; r1 = remainder; end
                if (ndone == 2) begin c2 = cyc; q2 = quotient; r2 = remainder; start = 1'b0; end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 2 || c1 != 9 || c2 != 19) begin
            errors++; $display("FAIL b2b_timing n=%0d c1=%0d c2=%0d exp=2/9/19", ndone, c1, c2);
        end
        checks++;
        if (q1 !== 8'd28 || r1 !== 4'd4 || q2 !== 8'd10 || r2 !== 4'd0) begin
            errors++; $display("FAIL b2b_result got=%0d/%0d %0d/%0d exp=28/4 10/0", q1, r1, q2, r2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            check_op("random", 8'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                check_op("sweep", 8'(a), 4'(b));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_abort();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
